// File: rtl/coax_rx_packer_pkg.sv
// coax_rx_packer shared types: FSM states, record flags, record encoder.
// Every record is two bytes: flags OR'd with value[9:8], then value[7:0].
package coax_rx_packer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DATA_HI,
    DATA_LO,
    SETTLE,
    EOF_HI,
    EOF_LO,
    ERR_HI,
    ERR_LO,
    HALT
  } state_t;

  localparam logic [7:0] FLAG_DATA  = 8'h00;
  localparam logic [7:0] FLAG_ERROR = 8'h80;
  localparam logic [7:0] FLAG_EOF   = 8'h40;

  function automatic logic [15:0] rec_encode(
    input logic [7:0] flags,
    input logic [9:0] val
  );
    return {flags | {6'b0, val[9:8]}, val[7:0]};
  endfunction

endpackage

// File: rtl/coax_rx_packer_if.sv
// Host-side byte stream: valid/ready handshake carrying one byte.
// The packer drives it as master; the host bridge is the slave.
interface coax_rx_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/coax_rx_packer.sv
// Drains the coax receive word FIFO into a host byte stream,
// adding per-frame EOF records and a one-shot error record.
module coax_rx_packer
  import coax_rx_packer_pkg::*;
#(
  parameter bit EMIT_EOF    = 1'b1,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               rx_data,
  input  logic                     rx_empty,
  input  logic                     rx_error,
  input  logic                     rx_active,
  output logic                     rx_read_strobe,
  coax_rx_packer_if.master         host,
  output logic                     busy
);

  state_t state_q, state_d;

  logic [9:0]             word_q, word_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic                   open_q, open_d;
  logic [9:0]             cnt_rep;
  logic                   strobe;
  logic                   valid;
  logic [7:0]             obyte;
  logic [15:0]            rec_data;
  logic [15:0]            rec_err;
  logic [15:0]            rec_eof;

  // Only the low 10 bits of the count fit in an EOF record.
  if (COUNT_WIDTH >= 10) begin : g_cnt_wide
    assign cnt_rep = cnt_q[9:0];
  end else begin : g_cnt_narrow
    assign cnt_rep = {{(10-COUNT_WIDTH){1'b0}}, cnt_q};
  end

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign rec_data = rec_encode(FLAG_DATA, word_q);
  assign rec_err  = rec_encode(FLAG_ERROR, word_q);
  assign rec_eof  = rec_encode(FLAG_EOF, cnt_rep);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      open_q  <= open_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    open_d  = open_q;
    strobe  = 1'b0;
    valid   = 1'b0;
    obyte   = 8'h00;
    unique case (state_q)
      IDLE: begin
        // The error code rides on rx_data; reuse the word register.
        if (rx_error) begin
          word_d  = rx_data;
          state_d = ERR_HI;
        end else if (!rx_empty) begin
          word_d  = rx_data;
          strobe  = 1'b1;
          open_d  = 1'b1;
          state_d = DATA_HI;
        end else if (EMIT_EOF && open_q && !rx_active) begin
          state_d = EOF_HI;
        end
      end
      DATA_HI: begin
        valid = 1'b1;
        obyte = rec_data[15:8];
        if (host.out_ready) state_d = DATA_LO;
      end
      DATA_LO: begin
        valid = 1'b1;
        obyte = rec_data[7:0];
        if (host.out_ready) begin
          cnt_d   = cnt_inc;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      EOF_HI: begin
        valid = 1'b1;
        obyte = rec_eof[15:8];
        if (host.out_ready) state_d = EOF_LO;
      end
      EOF_LO: begin
        valid = 1'b1;
        obyte = rec_eof[7:0];
        if (host.out_ready) begin
          cnt_d   = '0;
          open_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ERR_HI: begin
        valid = 1'b1;
        obyte = rec_err[15:8];
        if (host.out_ready) state_d = ERR_LO;
      end
      ERR_LO: begin
        valid = 1'b1;
        obyte = rec_err[7:0];
        if (host.out_ready) state_d = HALT;
      end
      HALT: begin
        if (!rx_error) begin
          cnt_d   = '0;
          open_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset silences every output in the same cycle it is asserted.
  assign rx_read_strobe = strobe & ~reset;
  assign host.out_valid = valid & ~reset;
  assign host.out_data  = reset ? 8'h00 : obyte;
  assign busy           = (state_q != IDLE) & ~reset;

endmodule

// File: doc/coax_rx_packer.md
Name: coax_rx_packer

Overview:
- Drains the 10-bit word FIFO of coax_buffered_rx and serialises its contents into a byte stream for the host interface (SPI/UART bridge).
- Connects to the FIFO's data/empty/error/read_strobe, plus the receiver's active flag.
- Sits directly downstream of coax_buffered_rx and directly upstream of the host byte interface.
- Adds per-frame end-of-frame (EOF) records with a word count, and a one-shot error record.

Parameters:
- EMIT_EOF, 1, when 1 emit an EOF record after each frame; when 0 suppress EOF records.
- COUNT_WIDTH, 10, width of the frame word counter; the count saturates at 2^COUNT_WIDTH-1 and at most 10 bits are reported.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  10  FIFO head word; carries the error code while rx_error=1
- rx_empty  in  1  FIFO empty
- rx_error  in  1  sticky receiver error (e.g. ERROR_OVERFLOW)
- rx_active  in  1  receiver is mid-frame
- rx_read_strobe  out  1  one-cycle FIFO pop
- out_data  out  8  byte to host
- out_valid  out  1  out_data is valid
- out_ready  in  1  host accepts the byte
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset
  - All outputs 0; state IDLE; word register 0; count 0; frame_open 0.
  - Reset wins over every other event in every state; an unfinished byte pair is abandoned and no strobe is issued.
- Handshake
  - A byte transfers on a cycle where out_valid & out_ready.
  - Once out_valid rises, out_data stays stable and out_valid stays high until the transfer.
- Record encoding, high byte then low byte:
  - Data word: hi = {1'b0, 1'b0, 4'b0, w[9:8]}, lo = w[7:0].
  - Error record: hi = {1'b1, 1'b0, 4'b0, code[9:8]}, lo = code[7:0].
  - EOF record: hi = {1'b0, 1'b1, 4'b0, cnt[9:8]}, lo = cnt[7:0].
- States: IDLE, DATA_HI, DATA_LO, SETTLE, EOF_HI, EOF_LO, ERR_HI, ERR_LO, HALT.
- IDLE evaluates conditions in priority order:
  1. rx_error: latch rx_data as the error code -> ERR_HI.
  2. !rx_empty: latch rx_data into the word register, pulse rx_read_strobe this cycle, set frame_open -> DATA_HI.
  3. EMIT_EOF & frame_open & rx_empty & !rx_active -> EOF_HI.
- DATA_HI: present hi; on transfer -> DATA_LO.
- DATA_LO: present lo; on transfer, cnt <= sat(cnt+1) -> SETTLE.
- SETTLE: one idle cycle so FIFO empty/data reflect the pop -> IDLE.
- EOF_HI -> EOF_LO (on transfer).
- EOF_LO: on transfer, cnt <= 0, frame_open <= 0 -> IDLE.
- ERR_HI -> ERR_LO (on transfer).
- ERR_LO: on transfer -> HALT.
- HALT: no strobes and no output; stays until rx_error=0, then cnt <= 0, frame_open <= 0 -> IDLE. The error record is emitted exactly once per error episode.
- Words left in the FIFO when rx_error is seen are not drained; the error record replaces them.
- With EMIT_EOF=0, frame_open/cnt still track a frame but clear only on error recovery or reset. EOF_* states are unreachable.
- Latency: the first data hi byte is valid 1 cycle after IDLE sees !rx_empty (rx_read_strobe is in the same cycle as the latch).
- Minimum per-word period: 4 cycles with out_ready held high.
- rx_read_strobe is never high for two consecutive cycles and never high while rx_empty=1.

Decomposition:
- Package coax_rx_packer_pkg holds:
  - state enum;
  - FLAG_ERROR = 8'h80 and FLAG_EOF = 8'h40;
  - record-encode function (flags, 10-bit value) -> {hi, lo}.
- No sub-module; a single FSM with a word register and counter.

Test Plan:
- Upstream FIFO model preloaded with 0x001, 0x203; rx_active=0; out_ready=1 -> bytes 00 01 02 03 40 02; exactly 2 rx_read_strobe pulses; busy returns to 0.
- Same stimulus with out_ready toggling 1,0,1,0 -> identical byte sequence; out_data is stable across every stall cycle; no duplicate or dropped bytes.
- rx_active=1 with FIFO empty after 3 words -> no EOF until rx_active falls; then bytes 40 03.
- rx_error=1 with rx_data=0x3FE and FIFO full (8 words) -> bytes 83 FE only, no strobes; busy stays 1 until rx_error=0, then IDLE with cnt=0 and no EOF.
- Reset asserted in DATA_LO while out_ready=0 -> the next cycle has out_valid=0, rx_read_strobe=0, busy=0; a subsequent word restarts with count 1 (EOF lo = 01).
- EMIT_EOF=0 with 2 words -> bytes 00 xx 00 yy only; no 0x40 byte ever appears.
